seq_divider: RTL and testbench



---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 128 ++++++++++++
 tb/tb_seq_divider.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider; master drives requests, slave returns results.
interface seq_divider_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             ov_flag;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, ov_flag
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, ov_flag
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one trial subtraction per clock, MSB first.
// Define SIGNED_DIV_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_divider #(
    parameter int WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_dvd_sh, r_divisor, r_partial, r_quot;
    logic [WIDTH-1:0] r_q_out, r_r_out;
    logic [CW-1:0]    r_cnt;
    logic             r_done, r_dbz;

    logic             w_accept, w_last, w_borrow;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_shift, w_part_nxt, w_quot_nxt;
    logic [WIDTH-1:0] w_q_fix, w_r_fix;
    logic [WIDTH:0]   w_trial;

`ifdef SIGNED_DIV_EN
    logic r_neg_q, r_neg_r, r_ovc, r_ov;
    logic w_a_neg, w_b_neg, w_ovc;

    assign w_a_neg = bus.dividend[WIDTH-1];
    assign w_b_neg = bus.divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~bus.dividend + ONE) : bus.dividend;
    assign w_b_mag = w_b_neg ? (~bus.divisor + ONE) : bus.divisor;
    assign w_ovc   = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
    assign w_q_fix = r_neg_q ? (~w_quot_nxt + ONE) : w_quot_nxt;
    assign w_r_fix = r_neg_r ? (~w_part_nxt + ONE) : w_part_nxt;
    assign bus.ov_flag = r_ov;
`else
    assign w_a_mag = bus.dividend;
    assign w_b_mag = bus.divisor;
    assign w_q_fix = w_quot_nxt;
    assign w_r_fix = w_part_nxt;
    assign bus.ov_flag = 1'b0;
`endif

    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_last     = (r_state == CALC) && (r_cnt == CW'(WIDTH - 1));
    assign w_shift    = {r_partial[WIDTH-2:0], r_dvd_sh[WIDTH-1]};
    assign w_trial    = {1'b0, w_shift} - {1'b0, r_divisor};
    assign w_borrow   = w_trial[WIDTH];
    assign w_part_nxt = w_borrow ? w_shift : w_trial[WIDTH-1:0];
    assign w_quot_nxt = {r_quot[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.start) w_next = (w_b_mag == '0) ? DONE : CALC;
            CALC: if (w_last) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd_sh  <= '0;
            r_divisor <= '0;
            r_partial <= '0;
            r_quot    <= '0;
            r_q_out   <= '0;
            r_r_out   <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_ovc     <= 1'b0;
            r_ov      <= 1'b0;
`endif
        end else begin
            // done trails the DONE state by one edge so both paths meet the fixed latencies
            r_done <= (r_state == DONE);
            if (w_accept) begin
                r_dvd_sh  <= w_a_mag;
                r_divisor <= w_b_mag;
                r_partial <= '0;
                r_quot    <= '0;
                r_cnt     <= '0;
                r_dbz     <= 1'b0;
`ifdef SIGNED_DIV_EN
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                r_ovc     <= w_ovc;
                r_ov      <= 1'b0;
`endif
                if (w_b_mag == '0) begin
                    r_q_out <= '1;
                    r_r_out <= bus.dividend;
                    r_dbz   <= 1'b1;
                end
            end else if (r_state == CALC) begin
                r_partial <= w_part_nxt;
                r_quot    <= w_quot_nxt;
                r_dvd_sh  <= r_dvd_sh << 1;
                r_cnt     <= r_cnt + CW'(1);
                if (w_last) begin
                    r_q_out <= w_q_fix;
                    r_r_out <= w_r_fix;
`ifdef SIGNED_DIV_EN
                    r_ov    <= r_ovc;
`endif
                end
            end
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.quotient    = r_q_out;
    assign bus.remainder   = r_r_out;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider with hand-computed quotient/remainder.
module tb_seq_divider;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst;

    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dbz, input logic ov);
        vec_t v;
        v.dvd = a; v.dvs = b; v.q = q; v.r = r; v.dbz = dbz; v.ov = ov;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dbz, input logic ov);
        check({tag, "_q"},   32'(bus.quotient),    32'(q));
        check({tag, "_r"},   32'(bus.remainder),   32'(r));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(dbz));
        check({tag, "_ov"},  32'(bus.ov_flag),     32'(ov));
    endtask

    // Issues one request, then watches a bounded 20-cycle window; cycle k is the one after edge k-1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj_cycle,
                          output int first_done, output int n_done);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
        first_done = -1;
        n_done = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.done) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (k == inj_cycle) begin
                bus.start = 1'b1; bus.dividend = W'(1); bus.divisor = W'(1);
            end else if (k == inj_cycle + 1) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int fd, nd, d1, d2;
        bit busy_seen;

`ifdef SIGNED_DIV_EN
        tbl.push_back(mk(5'b11001, 5'd2,     5'b11101, 5'b11111, 1'b0, 1'b0)); // -7 / 2
        tbl.push_back(mk(5'b10000, 5'b11111, 5'b10000, 5'd0,     1'b0, 1'b1)); // -16 / -1
        tbl.push_back(mk(5'd9,     5'b11100, 5'b11110, 5'd1,     1'b0, 1'b0)); // 9 / -4
        tbl.push_back(mk(5'd7,     5'd0,     5'b11111, 5'd7,     1'b1, 1'b0));
        tbl.push_back(mk(5'd10,    5'd2,     5'd5,     5'd0,     1'b0, 1'b0));
        tbl.push_back(mk(5'b11011, 5'd0,     5'b11111, 5'b11011, 1'b1, 1'b0)); // -5 / 0
        tbl.push_back(mk(5'd15,    5'd4,     5'd3,     5'd3,     1'b0, 1'b0));
        tbl.push_back(mk(5'b10001, 5'b11100, 5'd3,     5'b11101, 1'b0, 1'b0)); // -15 / -4
        tbl.push_back(mk(5'b10000, 5'd1,     5'b10000, 5'd0,     1'b0, 1'b0)); // -16 / 1
        tbl.push_back(mk(5'd0,     5'b11101, 5'd0,     5'd0,     1'b0, 1'b0)); // 0 / -3
`else
        tbl.push_back(mk(5'd23, 5'd5,  5'd4,     5'd3,  1'b0, 1'b0));
        tbl.push_back(mk(5'd31, 5'd1,  5'd31,    5'd0,  1'b0, 1'b0));
        tbl.push_back(mk(5'd3,  5'd9,  5'd0,     5'd3,  1'b0, 1'b0));
        tbl.push_back(mk(5'd7,  5'd0,  5'b11111, 5'd7,  1'b1, 1'b0));
        tbl.push_back(mk(5'd10, 5'd2,  5'd5,     5'd0,  1'b0, 1'b0));
        tbl.push_back(mk(5'd30, 5'd7,  5'd4,     5'd2,  1'b0, 1'b0));
        tbl.push_back(mk(5'd31, 5'd31, 5'd1,     5'd0,  1'b0, 1'b0));
        tbl.push_back(mk(5'd0,  5'd5,  5'd0,     5'd0,  1'b0, 1'b0));
        tbl.push_back(mk(5'd1,  5'd31, 5'd0,     5'd1,  1'b0, 1'b0));
        tbl.push_back(mk(5'd25, 5'd13, 5'd1,     5'd12, 1'b0, 1'b0));
`endif

        rst = 1'b1;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check_outs("rst", '0, '0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].dvd, tbl[i].dvs, -1, fd, nd);
            check($sformatf("v%0d_lat", i), 32'(fd), (tbl[i].dvs == '0) ? 32'd2 : 32'(W + 2));
            check($sformatf("v%0d_ndone", i), 32'(nd), 32'd1);
            check_outs($sformatf("v%0d", i), tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].ov);
        end

        // busy follows the accepting edge
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 5'd12; bus.divisor = 5'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_rise", 32'(bus.busy), 32'd1);
        repeat (10) @(negedge clk);
        check_outs("busy_op", 5'd2, 5'd2, 1'b0, 1'b0);

        // second request while busy is ignored
        run_op(5'd11, 5'd5, 3, fd, nd);
        check("ign_lat", 32'(fd), 32'(W + 2));
        check("ign_ndone", 32'(nd), 32'd1);
        check_outs("ign", 5'd2, 5'd1, 1'b0, 1'b0);

        // async reset mid-operation
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 5'd14; bus.divisor = 5'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check_outs("arst", '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        busy_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done) nd++;
            if (bus.busy) busy_seen = 1'b1;
        end
        check("arst_nodone", 32'(nd), 32'd0);
        check("arst_idle", 32'(busy_seen), 32'd0);
        run_op(5'd14, 5'd4, -1, fd, nd);
        check("arst_re_lat", 32'(fd), 32'(W + 2));
        check_outs("arst_re", 5'd3, 5'd2, 1'b0, 1'b0);

        // start held high: back-to-back acceptance
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 5'd13; bus.divisor = 5'd3;
        d1 = -1; d2 = -1; nd = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        bus.start = 1'b0;
        check("held_d1", 32'(d1), 32'(W + 2));
        check("held_d2", 32'(d2), 32'(2 * (W + 2)));
        check("held_nd", 32'(nd), 32'd2);
        repeat (10) @(negedge clk);
        check_outs("held", 5'd4, 5'd1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
